// File: rtl/atm_auth.sv
// -----------------------------------------------------------------------------
// atm_auth -- authentication front end for the atm transaction core.
//
// Accepts a card number / PIN request, scans a fixed four-entry account table
// one entry per clock, tracks consecutive PIN failures per account (locking an
// account after MAX_TRIES bad PINs) and, on success, opens a session that
// presents the account index to atm until logout or an idle timeout.
//
// Optional feature (macro AUTH_UNLOCK_EN): adds admin_unlock / unlock_idx,
// which clear the lock bit and fail counter of one account on the next edge.
// Without the macro those ports do not exist and locks persist until reset.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   admin_unlock     in   (AUTH_UNLOCK_EN only) unlock strobe
//   unlock_idx [1:0] in   (AUTH_UNLOCK_EN only) account to unlock
//   req_valid        in   authentication request present
//   req_ready        out  request can be accepted (high only in IDLE)
//   card_number[11:0]in   card number, sampled on handshake
//   pin_number [7:0] in   PIN, sampled on handshake
//   logout           in   end current session
//   activity         in   transaction strobe from atm, restarts idle timer
//   auth_ok          out  one-cycle pulse: authentication passed
//   auth_fail        out  one-cycle pulse: authentication rejected
//   fail_code  [1:0] out  01 unknown card, 10 bad PIN, 11 locked
//   session_active   out  session open
//   acct_idx   [1:0] out  table index of the session account
//   session_timeout  out  one-cycle pulse when a session times out
//   locked_flags[3:0]out  per-account lock bits
// -----------------------------------------------------------------------------
module atm_auth #(
  parameter int NUM_ACCOUNTS   = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
`ifdef AUTH_UNLOCK_EN
  input  logic        admin_unlock,
  input  logic [1:0]  unlock_idx,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] card_number,
  input  logic [7:0]  pin_number,
  input  logic        logout,
  input  logic        activity,
  output logic        auth_ok,
  output logic        auth_fail,
  output logic [1:0]  fail_code,
  output logic        session_active,
  output logic [1:0]  acct_idx,
  output logic        session_timeout,
  output logic [3:0]  locked_flags
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SCAN    = 2'd1;
  localparam logic [1:0] S_SESSION = 2'd2;

  localparam logic [1:0] CODE_UNKNOWN = 2'b01;
  localparam logic [1:0] CODE_BAD_PIN = 2'b10;
  localparam logic [1:0] CODE_LOCKED  = 2'b11;

  localparam logic [1:0] LAST_IDX  = 2'(NUM_ACCOUNTS - 1);
  localparam logic [1:0] TRIES_LIM = 2'(MAX_TRIES);

  localparam int              IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  // Fixed account table.
  function automatic logic [11:0] table_card(input logic [1:0] idx);
    case (idx)
      2'd0:    table_card = 12'd1873;
      2'd1:    table_card = 12'd1988;
      2'd2:    table_card = 12'd2133;
      default: table_card = 12'd2500;
    endcase
  endfunction

  function automatic logic [7:0] table_pin(input logic [1:0] idx);
    case (idx)
      2'd0:    table_pin = 8'h4F;
      2'd1:    table_pin = 8'h24;
      2'd2:    table_pin = 8'h5A;
      default: table_pin = 8'h99;
    endcase
  endfunction

  // State registers and their next-state values.
  logic [1:0]        state, state_d;
  logic [1:0]        scan_idx, scan_idx_d;
  logic [11:0]       card_q, card_d;
  logic [7:0]        pin_q, pin_d;
  logic [3:0][1:0]   fail_cnt, fail_cnt_d;
  logic [3:0]        lock_q, lock_d;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
  logic              auth_ok_d, auth_fail_d, timeout_d;
  logic [1:0]        fail_code_d, acct_idx_d;

  // Unlock request, tied off when the feature is compiled out.
  logic       unlock_hit;
  logic [1:0] unlock_sel;
`ifdef AUTH_UNLOCK_EN
  assign unlock_hit = admin_unlock;
  assign unlock_sel = unlock_idx;
`else
  assign unlock_hit = 1'b0;
  assign unlock_sel = 2'd0;
`endif

  // Lock/counter state as seen by this cycle's decision: an unlock landing on
  // the same edge as a SCAN decision wins, so the decision sees cleared state.
  logic [3:0]      eff_lock;
  logic [3:0][1:0] eff_cnt;
  logic [1:0]      bumped_cnt;

  always_comb begin
    eff_lock = lock_q;
    eff_cnt  = fail_cnt;
    if (unlock_hit) begin
      eff_lock[unlock_sel] = 1'b0;
      eff_cnt[unlock_sel]  = 2'd0;
    end
  end

  // Saturating increment of the scanned account's fail counter.
  assign bumped_cnt = (eff_cnt[scan_idx] == 2'd3) ? 2'd3 : eff_cnt[scan_idx] + 2'd1;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state;
    scan_idx_d  = scan_idx;
    card_d      = card_q;
    pin_d       = pin_q;
    fail_cnt_d  = eff_cnt;
    lock_d      = eff_lock;
    idle_cnt_d  = idle_cnt;
    auth_ok_d   = 1'b0;
    auth_fail_d = 1'b0;
    timeout_d   = 1'b0;
    fail_code_d = fail_code;
    acct_idx_d  = acct_idx;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_SCAN;
          scan_idx_d = 2'd0;
          card_d     = card_number;
          pin_d      = pin_number;
        end
      end

      S_SCAN: begin
        if (card_q == table_card(scan_idx)) begin
          if (eff_lock[scan_idx]) begin
            auth_fail_d = 1'b1;
            fail_code_d = CODE_LOCKED;
            state_d     = S_IDLE;
          end else if (pin_q != table_pin(scan_idx)) begin
            fail_cnt_d[scan_idx] = bumped_cnt;
            auth_fail_d          = 1'b1;
            state_d              = S_IDLE;
            if (bumped_cnt >= TRIES_LIM) begin
              lock_d[scan_idx] = 1'b1;
              fail_code_d      = CODE_LOCKED;
            end else begin
              fail_code_d = CODE_BAD_PIN;
            end
          end else begin
            fail_cnt_d[scan_idx] = 2'd0;
            auth_ok_d            = 1'b1;
            acct_idx_d           = scan_idx;
            idle_cnt_d           = IDLE_LOAD;
            state_d              = S_SESSION;
          end
        end else if (scan_idx == LAST_IDX) begin
          auth_fail_d = 1'b1;
          fail_code_d = CODE_UNKNOWN;
          state_d     = S_IDLE;
        end else begin
          scan_idx_d = scan_idx + 2'd1;
        end
      end

      S_SESSION: begin
        // Logout beats activity; the timeout fires on the edge where the idle
        // counter would reach zero, together with session_active falling.
        if (logout) begin
          state_d = S_IDLE;
        end else if (activity) begin
          idle_cnt_d = IDLE_LOAD;
        end else if (idle_cnt == IDLE_ONE) begin
          idle_cnt_d = '0;
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt - IDLE_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      scan_idx        <= 2'd0;
      card_q          <= '0;
      pin_q           <= '0;
      // NOTE: the per-account fail counters and lock bits are architectural
      // state that reset must clear, unlike a data buffer that needs no reset.
      fail_cnt        <= '0;
      lock_q          <= '0;
      idle_cnt        <= '0;
      auth_ok         <= 1'b0;
      auth_fail       <= 1'b0;
      fail_code       <= 2'b00;
      acct_idx        <= 2'd0;
      session_timeout <= 1'b0;
    end else begin
      state           <= state_d;
      scan_idx        <= scan_idx_d;
      card_q          <= card_d;
      pin_q           <= pin_d;
      fail_cnt        <= fail_cnt_d;
      lock_q          <= lock_d;
      idle_cnt        <= idle_cnt_d;
      auth_ok         <= auth_ok_d;
      auth_fail       <= auth_fail_d;
      fail_code       <= fail_code_d;
      acct_idx        <= acct_idx_d;
      session_timeout <= timeout_d;
    end
  end

  assign req_ready      = (state == S_IDLE);
  assign session_active = (state == S_SESSION);
  assign locked_flags   = lock_q;

endmodule

// File: tb/tb_atm_auth.sv
// -----------------------------------------------------------------------------
// tb_atm_auth -- scoreboard bench for atm_auth (TIMEOUT_CYCLES = 16).
// Stimulus pushes the expected result pulse (kind, cycle, code, index, lock
// bits) into a queue; a monitor pops and compares whenever a pulse appears.
// -----------------------------------------------------------------------------
module tb_atm_auth;

  typedef enum int {EV_OK, EV_FAIL, EV_TIMEOUT} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic [1:0] code;
    logic [1:0] idx;
    logic [3:0] locked;
    int         at;
  } exp_t;

`ifdef AUTH_UNLOCK_EN
  localparam logic [3:0] LOCK_AFTER = 4'b0000;
`else
  localparam logic [3:0] LOCK_AFTER = 4'b0010;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [11:0] card_number = '0;
  logic [7:0]  pin_number = '0;
  logic        logout = 1'b0;
  logic        activity = 1'b0;
`ifdef AUTH_UNLOCK_EN
  logic        admin_unlock = 1'b0;
  logic [1:0]  unlock_idx = '0;
`endif
  logic        req_ready, auth_ok, auth_fail, session_active, session_timeout;
  logic [1:0]  fail_code, acct_idx;
  logic [3:0]  locked_flags;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  atm_auth #(.NUM_ACCOUNTS(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .reset           (reset),
`ifdef AUTH_UNLOCK_EN
    .admin_unlock    (admin_unlock),
    .unlock_idx      (unlock_idx),
`endif
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .card_number     (card_number),
    .pin_number      (pin_number),
    .logout          (logout),
    .activity        (activity),
    .auth_ok         (auth_ok),
    .auth_fail       (auth_fail),
    .fail_code       (fail_code),
    .session_active  (session_active),
    .acct_idx        (acct_idx),
    .session_timeout (session_timeout),
    .locked_flags    (locked_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t kind, input logic [1:0] code, input logic [1:0] idx,
                           input logic [3:0] locked, input int at);
    exp_t e;
    e.kind = kind; e.code = code; e.idx = idx; e.locked = locked; e.at = at;
    sb.push_back(e);
  endtask

  // Monitor: any result pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] exp_vec;
    if (auth_ok || auth_fail || session_timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, auth_ok, auth_fail, session_timeout}, 32'd0);
      end else begin
        e = sb.pop_front();
        case (e.kind)
          EV_OK:   exp_vec = 3'b100;
          EV_FAIL: exp_vec = 3'b010;
          default: exp_vec = 3'b001;
        endcase
        check("pulse_kind", {29'd0, auth_ok, auth_fail, session_timeout}, {29'd0, exp_vec});
        check("pulse_cycle", cyc, e.at);
        check("locked_flags", {28'd0, locked_flags}, {28'd0, e.locked});
        if (e.kind == EV_FAIL) check("fail_code", {30'd0, fail_code}, {30'd0, e.code});
        if (e.kind == EV_OK) begin
          check("acct_idx", {30'd0, acct_idx}, {30'd0, e.idx});
          check("session_on_ok", {31'd0, session_active}, 32'd1);
        end
        if (e.kind == EV_TIMEOUT) check("session_off_timeout", {31'd0, session_active}, 32'd0);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {23'd0, auth_ok, auth_fail, fail_code, session_active, acct_idx, session_timeout}, 32'd0);
    check("rst_locked", {28'd0, locked_flags}, 32'd0);
  endtask

  // Waits (bounded) for req_ready, then presents one request; returns the
  // cycle count right after the accepting edge.
  task automatic send_req(input logic [11:0] card, input logic [7:0] pin, output int acc);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; card_number = card; pin_number = pin;
    @(posedge clk); #1;
    req_valid = 1'b0; card_number = 12'hABC; pin_number = 8'hEE;
    acc = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic run(input logic [11:0] card, input logic [7:0] pin, input ev_kind_t kind,
                     input logic [1:0] code, input logic [1:0] idx, input logic [3:0] locked,
                     input int lat);
    int acc;
    send_req(card, pin, acc);
    expect_ev(kind, code, idx, locked, acc + lat);
    wait_drain(20);
  endtask

  task automatic do_logout();
    @(negedge clk);
    logout = 1'b1;
    @(posedge clk); #1;
    logout = 1'b0;
    @(negedge clk);
    check("logout_ends", {31'd0, session_active}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int acc;
    int a_edge;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;

    // Known card, right PIN on entry 0: result one cycle after acceptance.
    send_req(12'd1873, 8'h4F, acc);
    check("req_ready_drop", {31'd0, req_ready}, 32'd0);
    expect_ev(EV_OK, 2'b00, 2'd0, 4'b0000, acc + 1);
    wait_drain(20);
    do_logout();

    // Bad PIN on entry 2, unknown card, bad PIN again, then correct PIN.
    run(12'd2133, 8'h55, EV_FAIL, 2'b10, 2'd0, 4'b0000, 3);
    run(12'd1234, 8'h00, EV_FAIL, 2'b01, 2'd0, 4'b0000, 4);
    run(12'd2133, 8'h55, EV_FAIL, 2'b10, 2'd0, 4'b0000, 3);
    run(12'd2133, 8'h5A, EV_OK,   2'b00, 2'd2, 4'b0000, 3);
    do_logout();

    // Three bad PINs lock account 1; the right PIN is then still refused.
    run(12'd1988, 8'h00, EV_FAIL, 2'b10, 2'd0, 4'b0000, 2);
    run(12'd1988, 8'h00, EV_FAIL, 2'b10, 2'd0, 4'b0000, 2);
    run(12'd1988, 8'h00, EV_FAIL, 2'b11, 2'd0, 4'b0010, 2);
    run(12'd1988, 8'h24, EV_FAIL, 2'b11, 2'd0, 4'b0010, 2);
`ifdef AUTH_UNLOCK_EN
    @(negedge clk);
    admin_unlock = 1'b1; unlock_idx = 2'd1;
    @(posedge clk); #1;
    admin_unlock = 1'b0;
    check("unlock_clears", {28'd0, locked_flags}, 32'd0);
    run(12'd1988, 8'h24, EV_OK, 2'b00, 2'd1, 4'b0000, 2);
    do_logout();
`endif

    // Session with one activity strobe 10 cycles in, then idle timeout.
    run(12'd1873, 8'h4F, EV_OK, 2'b00, 2'd0, LOCK_AFTER, 1);
    repeat (9) @(negedge clk);
    activity = 1'b1;
    a_edge = cyc + 1;
    expect_ev(EV_TIMEOUT, 2'b00, 2'd0, LOCK_AFTER, a_edge + 16);
    @(posedge clk); #1;
    activity = 1'b0;
    wait_drain(40);
    @(negedge clk);
    check("idle_after_timeout", {31'd0, req_ready}, 32'd1);

    // Logout together with activity: session ends next edge, no timeout.
    run(12'd1873, 8'h4F, EV_OK, 2'b00, 2'd0, LOCK_AFTER, 1);
    repeat (3) @(negedge clk);
    logout = 1'b1; activity = 1'b1;
    @(posedge clk); #1;
    logout = 1'b0; activity = 1'b0;
    check("logout_wins_session", {31'd0, session_active}, 32'd0);
    check("logout_wins_ready", {31'd0, req_ready}, 32'd1);
    repeat (24) @(negedge clk);

    // Reset during SCAN of an unknown card: no result pulse may follow.
    send_req(12'd1234, 8'h11, acc);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during a session: no timeout pulse may follow.
    run(12'd1873, 8'h4F, EV_OK, 2'b00, 2'd0, 4'b0000, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    repeat (24) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_auth.md
Name: atm_auth

Overview:
- Front-end authentication stage that sits directly upstream of the atm transaction core.
- Accepts a card number and PIN request and scans a fixed on-chip account table, one entry per clock.
- Checks the PIN and tracks consecutive failures per account, locking an account after too many bad PINs.
- On success it opens a session: presents the account index to atm and holds it until logout or inactivity timeout.

Parameters:
- NUM_ACCOUNTS, 4, table depth; fixed at 4, so acct_idx is 2 bits.
- MAX_TRIES, 3, consecutive wrong PINs that lock an account (range 1..3).
- TIMEOUT_CYCLES, 64, session idle cycles before forced logout (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-high reset.
- req_valid  input  1  authentication request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- card_number  input  12  card number, sampled on handshake.
- pin_number  input  8  PIN, sampled on handshake.
- logout  input  1  end current session.
- activity  input  1  transaction strobe from atm; restarts the idle timer.
- auth_ok  output  1  one-cycle pulse: authentication passed.
- auth_fail  output  1  one-cycle pulse: authentication rejected.
- fail_code  output  2  valid with auth_fail: 01 unknown card, 10 bad PIN, 11 locked.
- session_active  output  1  session open; atm may transact.
- acct_idx  output  2  table index of the session account.
- session_timeout  output  1  one-cycle pulse when a session ends by timeout.
- locked_flags  output  4  per-account lock bits.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - req_ready=1. All other outputs are 0, including fail_code=00, acct_idx=0 and locked_flags=0.
  - Fail counters and lock bits clear. Reset is the only unlock path unless AUTH_UNLOCK_EN is defined.
  - Reset mid-scan or mid-session aborts with no result pulse.
- Account table, hard constants:
  - idx0: card 1873, PIN 8'h4F.
  - idx1: card 1988, PIN 8'h24.
  - idx2: card 2133, PIN 8'h5A.
  - idx3: card 2500, PIN 8'h99.
- Handshake:
  - A request is accepted on the edge where req_valid && req_ready (edge E0). card_number and pin_number are latched there.
  - Inputs are ignored at all other times.
  - req_ready is low from the cycle after E0 until the block returns to IDLE.
- FSM states: IDLE, SCAN, SESSION.
  - IDLE: on accept go to SCAN with scan index k=0.
  - SCAN, cycle after edge E0+k: compare entry k.
    - Card match and lock bit set: auth_fail, fail_code=11, return to IDLE.
    - Card match and PIN wrong: increment the fail counter. If the counter reaches MAX_TRIES, set the lock bit and report fail_code=11; otherwise report 10. Return to IDLE.
    - Card match and PIN right: clear the fail counter, assert auth_ok, load acct_idx=k, go to SESSION.
    - No match and k=3: auth_fail, fail_code=01, return to IDLE.
    - No match otherwise: k++.
  - Result latency: the pulse appears in the cycle after edge E0+k+1, i.e. k+1 cycles after acceptance. An unknown card takes 4 cycles.
  - fail_code holds its value until the next result.
  - SESSION:
    - session_active=1 and acct_idx is stable.
    - The idle counter is loaded with TIMEOUT_CYCLES on entry and reloaded on each activity cycle.
    - The counter decrements on each other cycle.
    - On logout: go to IDLE next edge, no timeout pulse.
    - On counter reaching 0: go to IDLE and pulse session_timeout in the same cycle session_active falls.
    - logout and activity in the same cycle: logout wins.
    - logout outside SESSION is ignored.
    - activity outside SESSION is ignored.
- Fail counter: saturating 2-bit per account, cleared only by a correct PIN or by reset. A locked account rejects even the correct PIN.
- auth_ok and auth_fail are never high together.

Optional Feature:
- Macro: AUTH_UNLOCK_EN.
- When defined:
  - Adds inputs admin_unlock (1 bit) and unlock_idx (2 bits).
  - An admin_unlock pulse clears lock bit and fail counter of unlock_idx on the next edge, in any state.
  - If an unlock coincides with the SCAN decision for the same account, the unlock takes priority and the decision uses the cleared state.
- When undefined: the ports do not exist and locks persist until reset.

Test Plan:
- Reset, then request 1873/8'h4F → req_ready drops, auth_ok 1 cycle after accept, acct_idx=0, session_active=1.
- Request 2133/8'h55 → auth_fail 3 cycles after accept, fail_code=10, session_active=0, locked_flags=0.
- Request 1234/any → auth_fail 4 cycles after accept, fail_code=01; fail counters unchanged.
- Three requests 1988/8'h00 → fail codes 10, 10, 11 and locked_flags=4'b0010. Then 1988/8'h24 → fail_code=11. With AUTH_UNLOCK_EN, unlock_idx=1 then 1988/8'h24 → auth_ok.
- TIMEOUT_CYCLES=16, session on 1873 with activity 10 cycles in → session_timeout pulses 16 cycles after the activity. Second session with logout and activity in the same cycle → ends next edge, no timeout pulse.
- Reset asserted mid-SCAN and again mid-SESSION → no result pulse, all outputs at reset values, locked_flags=0.
